// File: rtl/dequan_ctrl.sv
// Frame dequantizer: reads 4-bit codes from BRAM, rebuilds 16-bit mid-bin
// coefficients and streams them in order under credit-limited backpressure.
module dequan_ctrl #(
  parameter int N_SAMPLES  = 256,
  parameter int ADDR_W     = 9,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  output logic              intr,
  output logic [ADDR_W-1:0] addrb_r,
  output logic              enb_r,
  input  logic [3:0]        doutb_quan,
  output logic [15:0]       out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [15:0]       data;
  } fifo_ent_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] iss_cnt_q, iss_cnt_d, cap_cnt_q, cap_cnt_d, dlv_cnt_q, dlv_cnt_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d, fcount_q, fcount_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  fifo_ent_t         mem_q [FIFO_DEPTH];
  fifo_ent_t         push_ent;
  logic              push, pop;

  always_comb begin
    // Credits cover both the BRAM pipe and the FIFO, so a capture always has a slot.
    enb_r     = (state_q == RUN) && ((inflight_q + fcount_q) < CNT_W'(FIFO_DEPTH));
    addrb_r   = iss_cnt_q;
    intr      = (state_q == DONE);
    out_valid = (fcount_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q].data : '0;
    out_idx   = out_valid ? mem_q[rd_ptr_q].idx  : '0;
    push      = vld_pipe_q[RD_LAT-1];
    pop       = out_valid && out_ready;
    push_ent.idx  = cap_cnt_q;
    push_ent.data = {doutb_quan, 12'h800} ^ 16'h8000;

    vld_pipe_d = RD_LAT'({vld_pipe_q, enb_r});
    iss_cnt_d  = iss_cnt_q + ADDR_W'(enb_r);
    cap_cnt_d  = cap_cnt_q + ADDR_W'(push);
    dlv_cnt_d  = dlv_cnt_q + ADDR_W'(pop);
    inflight_d = inflight_q + CNT_W'(enb_r) - CNT_W'(push);
    fcount_d   = fcount_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    state_d    = state_q;

    unique case (state_q)
      IDLE: if (start) begin
        state_d   = RUN;
        iss_cnt_d = '0;
        cap_cnt_d = '0;
        dlv_cnt_d = '0;
      end
      RUN:   if (enb_r && iss_cnt_q == ADDR_W'(N_SAMPLES - 1)) state_d = DRAIN;
      DRAIN: if (pop && dlv_cnt_q == ADDR_W'(N_SAMPLES - 1))   state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      iss_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      dlv_cnt_q  <= '0;
      inflight_q <= '0;
      fcount_q   <= '0;
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      dlv_cnt_q  <= dlv_cnt_d;
      inflight_q <= inflight_d;
      fcount_q   <= fcount_d;
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= push_ent;
  end

endmodule

// File: tb/tb_dequan_ctrl.sv
// Directed bench for dequan_ctrl: BRAM model, scoreboard queue of expected
// samples, and a negedge monitor checking addresses, ordering, hold and credits.
module tb_dequan_ctrl;
  localparam int N      = 256;
  localparam int ADDR_W = 9;
  localparam int RD_LAT = 1;
  localparam int FDEPTH = 4;

  typedef struct packed {
    logic [9:0]  idx;
    logic [15:0] data;
  } exp_t;

  logic              clk_in = 1'b0;
  logic              rst, start, intr, enb_r, out_valid, out_ready;
  logic [ADDR_W-1:0] addrb_r, out_idx;
  logic [3:0]        doutb_quan;
  logic [15:0]       out_data;

  logic [3:0]  bram    [0:255];
  logic [3:0]  rd_pipe [RD_LAT];
  logic [15:0] seen    [0:255];
  exp_t        q [$];

  int tests = 0, fails = 0, cyc = 0;
  int exp_addr, enb_cnt, xfer_cnt, intr_cnt, first_enb, first_vld, last_enb, last_xfer, intr_cyc;
  logic        held;
  logic [15:0] held_data;
  logic [8:0]  held_idx;

  dequan_ctrl #(.N_SAMPLES(N), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FDEPTH)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .intr(intr),
    .addrb_r(addrb_r), .enb_r(enb_r), .doutb_quan(doutb_quan),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (enb_r) rd_pipe[0] <= bram[addrb_r[7:0]];
  end
  assign doutb_quan = rd_pipe[RD_LAT-1];

  function automatic logic [15:0] recon(input logic [3:0] c);
    int v;
    v = (int'(c) - 8) * 4096 + 2048;
    return v[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    if (!rst) begin
      if (enb_r) begin
        chk("addr_seq", 32'(addrb_r), exp_addr);
        exp_addr++;
        enb_cnt++;
        if (first_enb < 0) first_enb = cyc;
        last_enb = cyc;
        chk("credit_bound", 32'((enb_cnt - xfer_cnt) <= FDEPTH), 1);
      end
      if (out_valid) begin
        exp_t e;
        if (first_vld < 0) first_vld = cyc;
        if (held) begin
          chk("hold_data", 32'(out_data), 32'(held_data));
          chk("hold_idx", 32'(out_idx), 32'(held_idx));
        end
        if (out_ready) begin
          e = (q.size() > 0) ? q.pop_front() : '{idx: 10'h3ff, data: 16'h0};
          chk("sb_idx", 32'(out_idx), 32'(e.idx));
          chk("sb_data", 32'(out_data), 32'(e.data));
          seen[out_idx[7:0]] = out_data;
          xfer_cnt++;
          if (out_idx == 9'd255) last_xfer = cyc;
          held = 1'b0;
        end else begin
          held = 1'b1; held_data = out_data; held_idx = out_idx;
        end
      end else held = 1'b0;
      if (intr) begin
        intr_cnt++;
        intr_cyc = cyc;
        chk("vld_in_done", 32'(out_valid), 0);
      end
    end
  end

  task automatic new_frame();
    q.delete();
    exp_addr = 0; enb_cnt = 0; xfer_cnt = 0; intr_cnt = 0;
    first_enb = -1; first_vld = -1; last_enb = 0; last_xfer = -1; intr_cyc = -1;
    held = 1'b0;
    for (int i = 0; i < N; i++) q.push_back('{idx: 10'(i), data: recon(bram[i])});
  endtask

  task automatic start_frame();
    new_frame();
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (intr_cnt == 0 && k < 5000) begin @(negedge clk_in); k++; end
    chk({tag, "_intr"}, intr_cnt, 1);
    repeat (4) @(posedge clk_in);
    #1;
    chk({tag, "_intr_once"}, intr_cnt, 1);
    chk({tag, "_q_empty"}, q.size(), 0);
    chk({tag, "_enb_total"}, enb_cnt, N);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_enb"}, 32'(enb_r), 0);
    chk({tag, "_intr0"}, 32'(intr), 0);
    chk({tag, "_vld"}, 32'(out_valid), 0);
    chk({tag, "_addr"}, 32'(addrb_r), 0);
    chk({tag, "_idx"}, 32'(out_idx), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) bram[i] = 4'(i % 16);
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 4'h0;
    new_frame();
    repeat (2) @(posedge clk_in);
    #1;
    chk_zero_outs("reset");
    rst = 1'b0;

    // Full-rate frame
    start_frame();
    wait_done("t1");
    chk("t1_latency", first_vld - first_enb, RD_LAT + 1);
    chk("t1_enb_span", last_enb - first_enb + 1, N);
    chk("t1_intr_after_last", intr_cyc - last_xfer, 1);

    // Downstream stalled from the start
    out_ready = 1'b0;
    start_frame();
    repeat (20) @(posedge clk_in);
    #1;
    chk("t2_issued", enb_cnt, FDEPTH);
    chk("t2_vld", 32'(out_valid), 1);
    chk("t2_idx", 32'(out_idx), 0);
    chk("t2_data", 32'(out_data), 32'(recon(bram[0])));
    out_ready = 1'b1;
    wait_done("t2");

    // Random backpressure, stray starts in RUN and in the DONE cycle
    start_frame();
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk_in); #1;
      out_ready = 1'($urandom_range(0, 1));
      start = (k == 10) || (intr === 1'b1);
      if (intr === 1'b1) break;
    end
    @(posedge clk_in); #1;
    start = 1'b0; out_ready = 1'b1;
    wait_done("t3");

    // Reset mid-frame with reads in flight
    start_frame();
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk_in); #1;
      if (xfer_cnt >= 100) break;
    end
    chk("t4_reached_100", 32'(xfer_cnt >= 100), 1);
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    chk_zero_outs("t4_rst");
    repeat (3) @(posedge clk_in);
    #1;
    chk("t4_no_stale", 32'(out_valid), 0);
    start_frame();
    wait_done("t4b");

    // Boundary codes
    for (int i = 0; i < N; i++) bram[i] = (i % 3 == 0) ? 4'd0 : (i % 3 == 1) ? 4'd8 : 4'd15;
    start_frame();
    wait_done("t5");
    chk("t5_code0", 32'(seen[0]), 32'h8800);
    chk("t5_code8", 32'(seen[1]), 32'h0800);
    chk("t5_code15", 32'(seen[2]), 32'h7800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dequan_ctrl.md
Name: dequan_ctrl

Overview:
- Playback-side counterpart of the quantization controller.
- On a start pulse, reads one frame of 4-bit quantization codes from the code BRAM and reconstructs each code into a 16-bit two's-complement MDCT coefficient.
- Streams the coefficients over a valid/ready interface to the IMDCT stage and raises intr when the frame is fully delivered.
- Contains a read pipeline, an in-flight credit counter and a small output FIFO, so downstream backpressure never drops or duplicates a sample.

Parameters:
- N_SAMPLES, 256, codes per frame; read addresses 0..N_SAMPLES-1.
- ADDR_W, 9, width of the BRAM address and of out_idx.
- RD_LAT, 1, BRAM read latency in cycles from an enb_r cycle to valid doutb_quan; legal values are 1 and 2.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least RD_LAT+2.

Ports:
- clk_in, input, 1, single clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle frame start pulse.
- intr, output, 1, one-cycle frame-done pulse.
- addrb_r, output, ADDR_W, BRAM read address.
- enb_r, output, 1, BRAM read enable; one read is issued per cycle in which it is high.
- doutb_quan, input, 4, BRAM read data, valid RD_LAT cycles after the enb_r cycle.
- out_data, output, 16, reconstructed coefficient, two's complement.
- out_idx, output, ADDR_W, sample index of out_data.
- out_valid, output, 1, out_data and out_idx are valid.
- out_ready, input, 1, downstream accepts; transfer occurs when out_valid && out_ready.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state:
  - state goes to IDLE; intr, enb_r and out_valid go to 0; addrb_r, out_idx and out_data go to 0.
  - FIFO is emptied; the credit counter and the issue and delivery counters are cleared.
  - A frame in progress is abandoned. Read data still in the BRAM pipe is discarded: the capture-valid shift register is cleared too.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 moves to RUN on the next cycle.
  - start is ignored in every other state; no queuing.
- RUN (issuing reads):
  - enb_r=1 in any cycle where inflight + fifo_count < FIFO_DEPTH, with addrb_r equal to the issue counter.
  - The issue counter increments on every enb_r cycle.
  - The first RUN cycle issues address 0 (the FIFO is empty).
  - After address N_SAMPLES-1 is issued, go to DRAIN; enb_r=0 from then on.
- inflight:
  - Increments on an issue and decrements on a capture; both in the same cycle leaves it unchanged.
  - A capture occurs RD_LAT cycles after an issue. A delay line of enable bits marks which cycles hold valid doutb_quan.
- Capture: out_data_next = {code, 12'h800} XOR 16'h8000, i.e. mid-bin reconstruction of the offset-binary uniform quantizer.
  - code 0 gives 16'h8800 (-30720).
  - code 8 gives 16'h0800 (+2048).
  - code 15 gives 16'h7800 (+30720).
  - The reconstructed word and its index are pushed into the FIFO.
- Output:
  - FIFO is show-ahead: out_valid = !empty, and out_data/out_idx come from the head.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full, because the credit rule guarantees a push never finds the FIFO full without a simultaneous pop.
  - out_data and out_idx must hold stable while out_valid=1 and out_ready=0.
- Latency: the first out_valid rises RD_LAT+1 cycles after the first enb_r cycle.
- Throughput: 1 sample per cycle when out_ready is held at 1.
- DRAIN: wait until the delivered count equals N_SAMPLES (the last pop), then go to DONE.
- DONE:
  - intr=1 for exactly one cycle, then return to IDLE.
  - A start arriving in the DONE cycle is ignored.
  - A start in the following IDLE cycle begins a new frame at address 0.
- Delivery order is strictly 0..N_SAMPLES-1.
- Each address is read exactly once per frame.
- out_valid is never high in IDLE or DONE.

Test Plan:
- Reset, then start with out_ready=1 and BRAM[i]=i mod 16:
  - enb_r is high 256 consecutive cycles, addresses 0..255.
  - The first out_valid comes 2 cycles after the first enb_r (RD_LAT=1).
  - out_data sequence is 8800,9800,...,7800 repeating; out_idx is 0..255.
  - intr pulses once, 1 cycle after the idx-255 transfer.
- out_ready held at 0 after start:
  - Exactly FIFO_DEPTH=4 reads are issued, then enb_r stays 0.
  - out_idx=0 holds with out_data stable.
  - Releasing out_ready resumes issue with no loss or duplicates (256 unique idx).
- Random out_ready at 50% duty, RD_LAT=1 and RD_LAT=2 builds:
  - Scoreboard matches all 256 samples in order.
  - FIFO never overflows.
  - intr count = 1.
- start pulsed during RUN and in the DONE cycle:
  - No effect: addresses never restart mid-frame, and a single intr per frame.
- rst=1 asserted mid-frame at sample 100 with reads in flight:
  - Next cycle all outputs are 0 and out_valid=0.
  - A subsequent start delivers idx 0..255 cleanly with no stale data.
- Boundary codes BRAM=0, 8, 15 -> out_data 16'h8800, 16'h0800, 16'h7800 respectively.
